// File: rtl/xor_cipher_ctrl_if.sv
// FIFO-side bus of the XOR cipher controller: RX read port, TX write port,
// rekey request and status.
interface xor_cipher_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             rx_empty;
    logic [7:0]       r_data;
    logic             rd_uart;
    logic             tx_full;
    logic             wr_uart;
    logic [7:0]       w_data;
    logic             rekey;
    logic             key_ready;
    logic [CNT_W-1:0] byte_count;

    modport master (
        input  rx_empty, r_data, tx_full, rekey,
        output rd_uart, wr_uart, w_data, key_ready, byte_count
    );

    modport slave (
        output rx_empty, r_data, tx_full, rekey,
        input  rd_uart, wr_uart, w_data, key_ready, byte_count
    );
endinterface

// File: rtl/xor_cipher_ctrl.sv
// Repeating-key XOR engine between a UART RX FIFO and TX FIFO. The first
// KEY_LEN bytes after reset/rekey form the key; later bytes are XORed and echoed.
module xor_cipher_ctrl #(
    parameter int unsigned KEY_LEN   = 4,
    parameter int unsigned KEY_IDX_W = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic           clk,
    input  logic           reset,
    xor_cipher_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        ST_KEY  = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [KEY_IDX_W-1:0] IDX_LAST = KEY_IDX_W'(KEY_LEN - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [KEY_IDX_W-1:0] r_idx;
    logic [KEY_IDX_W-1:0] w_idx_nxt;
    logic [7:0]           r_key [KEY_LEN];
    logic [7:0]           r_hold;
    logic [7:0]           w_hold_nxt;
    logic                 r_rekey_pend;
    logic                 w_rekey_pend_nxt;
    logic                 r_key_ready;
    logic                 w_key_ready_nxt;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_key_we;
    logic [KEY_IDX_W-1:0] w_key_widx;

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_hold_nxt       = r_hold;
        w_rekey_pend_nxt = r_rekey_pend;
        w_key_ready_nxt  = r_key_ready;
        w_count_nxt      = r_count;
        w_rd             = 1'b0;
        w_wr             = 1'b0;
        w_key_we         = 1'b0;
        w_key_widx       = r_idx;

        case (r_state)
            ST_KEY: begin
                // A rekey during loading restarts at slot 0; a byte popped in
                // the same cycle becomes the new key[0].
                w_key_widx = bus.rekey ? '0 : r_idx;
                w_idx_nxt  = w_key_widx;
                if (!bus.rx_empty) begin
                    w_rd     = 1'b1;
                    w_key_we = 1'b1;
                    if (w_key_widx == IDX_LAST) begin
                        w_idx_nxt       = '0;
                        w_key_ready_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_idx_nxt = w_key_widx + KEY_IDX_W'(1);
                    end
                end
            end

            ST_IDLE: begin
                if (bus.rekey || r_rekey_pend) begin
                    w_state_nxt      = ST_KEY;
                    w_idx_nxt        = '0;
                    w_key_ready_nxt  = 1'b0;
                    w_rekey_pend_nxt = 1'b0;
                end else if (!bus.rx_empty) begin
                    w_rd        = 1'b1;
                    w_hold_nxt  = bus.r_data ^ r_key[r_idx];
                    w_state_nxt = ST_SEND;
                end
            end

            ST_SEND: begin
                if (bus.rekey) begin
                    w_rekey_pend_nxt = 1'b1;
                end
                if (!bus.tx_full) begin
                    w_wr        = 1'b1;
                    w_count_nxt = r_count + CNT_W'(1);
                    w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + KEY_IDX_W'(1);
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_KEY;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_KEY;
            r_idx        <= '0;
            r_hold       <= '0;
            r_rekey_pend <= 1'b0;
            r_key_ready  <= 1'b0;
            r_count      <= '0;
            for (int unsigned i = 0; i < KEY_LEN; i++) begin
                r_key[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_hold       <= w_hold_nxt;
            r_rekey_pend <= w_rekey_pend_nxt;
            r_key_ready  <= w_key_ready_nxt;
            r_count      <= w_count_nxt;
            for (int unsigned i = 0; i < KEY_LEN; i++) begin
                if (w_key_we && (w_key_widx == KEY_IDX_W'(i))) begin
                    r_key[i] <= bus.r_data;
                end
            end
        end
    end

    // Strobes are masked while reset is held so no FIFO is touched during reset.
    assign bus.rd_uart    = w_rd & ~reset;
    assign bus.wr_uart    = w_wr & ~reset;
    assign bus.w_data     = r_hold;
    assign bus.key_ready  = r_key_ready;
    assign bus.byte_count = r_count;
endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Bench for xor_cipher_ctrl: FIFO queues on both sides and a repeating-key XOR
// model; a second instance covers KEY_LEN=1 and a 4-bit byte counter.
module tb_xor_cipher_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    xor_cipher_ctrl_if #(.CNT_W(16)) a_if ();
    xor_cipher_ctrl_if #(.CNT_W(4))  b_if ();

    xor_cipher_ctrl #(.KEY_LEN(4), .KEY_IDX_W(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.master)
    );
    xor_cipher_ctrl #(.KEY_LEN(1), .KEY_IDX_W(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.master)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] rxA[$], txA[$], expA[$];
    logic [7:0] rxB[$], txB[$], expB[$];
    logic [7:0] keyA [4];
    logic [7:0] keyB;
    int         nA, popsA, popsB;
    logic       rdA, wrA, rdB, wrB;
    logic [7:0] wdA, wdB;

    task automatic drive();
        a_if.rx_empty = (rxA.size() == 0);
        a_if.r_data   = (rxA.size() != 0) ? rxA[0] : 8'h00;
        b_if.rx_empty = (rxB.size() == 0);
        b_if.r_data   = (rxB.size() != 0) ? rxB[0] : 8'h00;
    endtask

    // Called on a falling edge; samples strobes, lets one rising edge pass,
    // then updates the FIFO models.
    task automatic step();
        #1;
        rdA = a_if.rd_uart; wrA = a_if.wr_uart; wdA = a_if.w_data;
        rdB = b_if.rd_uart; wrB = b_if.wr_uart; wdB = b_if.w_data;
        checks++;
        if ((rdA && a_if.rx_empty) || (wrA && a_if.tx_full) || (rdA && wrA)) begin
            failures++;
            $display("FAIL handshake_a: rd=%0b wr=%0b rx_empty=%0b tx_full=%0b, required no pop when empty, no push when full, never both",
                     rdA, wrA, a_if.rx_empty, a_if.tx_full);
        end
        checks++;
        if ((rdB && b_if.rx_empty) || (wrB && b_if.tx_full) || (rdB && wrB)) begin
            failures++;
            $display("FAIL handshake_b: rd=%0b wr=%0b rx_empty=%0b tx_full=%0b, required no pop when empty, no push when full, never both",
                     rdB, wrB, b_if.rx_empty, b_if.tx_full);
        end
        @(negedge clk);
        if (rdA && rxA.size() != 0) begin void'(rxA.pop_front()); popsA++; end
        if (wrA) txA.push_back(wdA);
        if (rdB && rxB.size() != 0) begin void'(rxB.pop_front()); popsB++; end
        if (wrB) txB.push_back(wdB);
        drive();
    endtask

    task automatic load_key_a(input logic [31:0] k);
        for (int i = 0; i < 4; i++) begin
            keyA[i] = k[31 - 8*i -: 8];
            rxA.push_back(keyA[i]);
        end
        nA = 0;
        drive();
    endtask

    task automatic send_a(input logic [7:0] pt);
        rxA.push_back(pt);
        expA.push_back(pt ^ keyA[nA % 4]);
        nA++;
        drive();
    endtask

    task automatic send_b(input logic [7:0] pt);
        rxB.push_back(pt);
        expB.push_back(pt ^ keyB);
        drive();
    endtask

    task automatic run_a(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && txA.size() < n; i++) step();
        ok = (txA.size() >= n);
    endtask

    task automatic pulse_rekey_a();
        a_if.rekey = 1'b1;
        step();
        a_if.rekey = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        a_if.rx_empty = 1'b0;
        b_if.rx_empty = 1'b0;
        #1;
        checks++;
        if (a_if.key_ready !== 1'b0 || a_if.byte_count !== 16'd0 || a_if.w_data !== 8'h00
            || a_if.rd_uart !== 1'b0 || a_if.wr_uart !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: kr=%b cnt=%h wd=%h rd=%b wr=%b, required all zero",
                     a_if.key_ready, a_if.byte_count, a_if.w_data, a_if.rd_uart, a_if.wr_uart);
        end
        checks++;
        if (b_if.key_ready !== 1'b0 || b_if.byte_count !== 4'd0 || b_if.w_data !== 8'h00
            || b_if.rd_uart !== 1'b0 || b_if.wr_uart !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: kr=%b cnt=%h wd=%h rd=%b wr=%b, required all zero",
                     b_if.key_ready, b_if.byte_count, b_if.w_data, b_if.rd_uart, b_if.wr_uart);
        end
        drive();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_key_stream();
        logic [7:0] want [5];
        bit ok;
        want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        load_key_a(32'h11223344);
        for (int i = 0; i < 20 && popsA < 3; i++) step();
        checks++;
        if (a_if.key_ready !== 1'b0 || popsA != 3) begin
            failures++;
            $display("FAIL key_partial: key_ready=%b pops=%0d, required 0 after 3 pops", a_if.key_ready, popsA);
        end
        step();
        checks++;
        if (a_if.key_ready !== 1'b1 || popsA != 4 || txA.size() != 0) begin
            failures++;
            $display("FAIL key_loaded: key_ready=%b pops=%0d tx=%0d, required 1 after 4 pops, no tx",
                     a_if.key_ready, popsA, txA.size());
        end
        for (int i = 0; i < 5; i++) send_a(8'h00);
        run_a(5, 60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stream_timeout: tx=%0d, required 5", txA.size());
        end
        for (int i = 0; i < 5 && i < txA.size(); i++) begin
            checks++;
            if (txA[i] !== want[i]) begin
                failures++;
                $display("FAIL stream_byte%0d: got %h, required %h", i, txA[i], want[i]);
            end
        end
        checks++;
        if (a_if.byte_count !== 16'd5) begin
            failures++;
            $display("FAIL stream_count: got %0d, required 5", a_if.byte_count);
        end
    endtask

    task automatic test_backpressure();
        int p0, n0, bad, wbad;
        logic [7:0] held;
        bit ok;
        a_if.tx_full = 1'b1;
        p0 = popsA; n0 = txA.size();
        send_a(8'($urandom)); send_a(8'($urandom));
        held = expA[n0];
        for (int i = 0; i < 10 && popsA == p0; i++) step();
        bad = 0; wbad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rdA || wrA) bad++;
            if (a_if.w_data !== held) wbad++;
        end
        checks++;
        if (bad != 0 || popsA != p0 + 1) begin
            failures++;
            $display("FAIL bp_hold: strobes=%0d pops=%0d, required 0 strobes and 1 pop", bad, popsA - p0);
        end
        checks++;
        if (wbad != 0) begin
            failures++;
            $display("FAIL bp_wdata: %0d cycles w_data != %h, required 0", wbad, held);
        end
        a_if.tx_full = 1'b0;
        step();
        checks++;
        if (txA.size() != n0 + 1 || (txA.size() > n0 && txA[n0] !== held)) begin
            failures++;
            $display("FAIL bp_release: pushes=%0d, required 1 of %h", txA.size() - n0, held);
        end
        run_a(n0 + 2, 20, ok);
        checks++;
        if (!ok || txA[n0+1] !== expA[n0+1]) begin
            failures++;
            $display("FAIL bp_next: got %0d bytes, required byte %h", txA.size() - n0, expA[n0+1]);
        end
    endtask

    task automatic test_rekey();
        int p0, n0;
        bit saw_kr0, ok;
        a_if.tx_full = 1'b1;
        p0 = popsA;
        send_a(8'($urandom));
        for (int i = 0; i < 10 && popsA == p0; i++) step();
        pulse_rekey_a();
        for (int i = 0; i < 3; i++) step();
        n0 = txA.size();
        load_key_a(32'hAABBCCDD);
        a_if.tx_full = 1'b0;
        p0 = popsA; saw_kr0 = 1'b0;
        for (int i = 0; i < 30 && popsA < p0 + 4; i++) begin
            step();
            if (a_if.key_ready === 1'b0) saw_kr0 = 1'b1;
        end
        checks++;
        if (txA.size() != n0 + 1 || (txA.size() > n0 && txA[n0] !== expA[n0])) begin
            failures++;
            $display("FAIL rekey_pending: pushes=%0d, required exactly 1 of %h", txA.size() - n0, expA[n0]);
        end
        checks++;
        if (!saw_kr0 || a_if.key_ready !== 1'b1 || popsA != p0 + 4) begin
            failures++;
            $display("FAIL rekey_load: saw_kr0=%b key_ready=%b pops=%0d, required 1/1/4",
                     saw_kr0, a_if.key_ready, popsA - p0);
        end
        for (int i = 0; i < 4; i++) send_a(8'($urandom));
        run_a(expA.size(), 60, ok);
        for (int i = n0 + 1; i < expA.size(); i++) begin
            checks++;
            if (i >= txA.size() || txA[i] !== expA[i]) begin
                failures++;
                $display("FAIL rekey_data%0d: got %h, required %h", i, (i < txA.size()) ? txA[i] : 8'hxx, expA[i]);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [7:0] pt [5];
        logic [7:0] ct [5];
        int n0;
        bit ok;
        pt = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        ct = '{8'h49, 8'h67, 8'h6F, 8'h68, 8'h6E};
        pulse_rekey_a();
        load_key_a(32'h01020304);
        n0 = txA.size();
        for (int i = 0; i < 5; i++) send_a(pt[i]);
        run_a(n0 + 5, 60, ok);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (n0 + i >= txA.size() || txA[n0+i] !== ct[i]) begin
                failures++;
                $display("FAIL rt_encrypt%0d: got %h, required %h", i, (n0+i < txA.size()) ? txA[n0+i] : 8'hxx, ct[i]);
            end
        end
        pulse_rekey_a();
        load_key_a(32'h01020304);
        for (int i = 0; i < 5; i++) send_a((n0 + i < txA.size()) ? txA[n0+i] : 8'h00);
        n0 = n0 + 5;
        run_a(n0 + 5, 60, ok);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (n0 + i >= txA.size() || txA[n0+i] !== pt[i]) begin
                failures++;
                $display("FAIL rt_decrypt%0d: got %h, required %h", i, (n0+i < txA.size()) ? txA[n0+i] : 8'hxx, pt[i]);
            end
        end
    endtask

    task automatic test_random();
        int n0, errs;
        pulse_rekey_a();
        load_key_a($urandom);
        n0 = txA.size();
        for (int i = 0; i < 40; i++) send_a(8'($urandom));
        for (int i = 0; i < 600 && txA.size() < expA.size(); i++) begin
            a_if.tx_full = ($urandom_range(0, 3) == 0);
            step();
        end
        a_if.tx_full = 1'b0;
        step();
        errs = 0;
        for (int i = n0; i < expA.size(); i++)
            if (i >= txA.size() || txA[i] !== expA[i]) errs++;
        checks++;
        if (errs != 0 || txA.size() != expA.size()) begin
            failures++;
            $display("FAIL random_stream: %0d wrong bytes, tx=%0d, required 0 wrong and %0d bytes", errs, txA.size(), expA.size());
        end
        checks++;
        if (a_if.byte_count !== 16'(expA.size())) begin
            failures++;
            $display("FAIL random_count: got %0d, required %0d", a_if.byte_count, expA.size());
        end
    endtask

    task automatic test_edges();
        int errs;
        keyB = 8'h5A;
        rxB.push_back(keyB);
        drive();
        for (int i = 0; i < 10 && popsB < 1; i++) step();
        checks++;
        if (b_if.key_ready !== 1'b1 || popsB != 1 || txB.size() != 0) begin
            failures++;
            $display("FAIL k1_load: key_ready=%b pops=%0d tx=%0d, required 1/1/0", b_if.key_ready, popsB, txB.size());
        end
        send_b(8'h5A);
        for (int i = 0; i < 16; i++) send_b(8'($urandom));
        for (int i = 0; i < 200 && txB.size() < 17; i++) step();
        checks++;
        if (txB.size() == 0 || txB[0] !== 8'h00) begin
            failures++;
            $display("FAIL k1_first: got %h, required 00", (txB.size() != 0) ? txB[0] : 8'hxx);
        end
        errs = 0;
        for (int i = 0; i < 17; i++)
            if (i >= txB.size() || txB[i] !== expB[i]) errs++;
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL k1_stream: %0d wrong bytes, required 0", errs);
        end
        checks++;
        if (b_if.byte_count !== 4'd1) begin
            failures++;
            $display("FAIL cnt_wrap: got %0d, required 1", b_if.byte_count);
        end
    endtask

    task automatic test_reset_mid_send();
        int p0;
        bit ok;
        a_if.tx_full = 1'b1;
        p0 = popsA;
        send_a(8'h5C);
        for (int i = 0; i < 10 && popsA == p0; i++) step();
        a_if.tx_full = 1'b0;
        #1;
        checks++;
        if (a_if.wr_uart !== 1'b1) begin
            failures++;
            $display("FAIL midsend_pre: wr_uart=%b, required 1", a_if.wr_uart);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (a_if.wr_uart !== 1'b0 || a_if.rd_uart !== 1'b0 || a_if.key_ready !== 1'b0
            || a_if.byte_count !== 16'd0 || a_if.w_data !== 8'h00) begin
            failures++;
            $display("FAIL midsend_reset: wr=%b rd=%b kr=%b cnt=%0d wd=%h, required all zero",
                     a_if.wr_uart, a_if.rd_uart, a_if.key_ready, a_if.byte_count, a_if.w_data);
        end
        @(negedge clk);
        rxA.delete(); txA.delete(); expA.delete(); rxB.delete(); txB.delete(); expB.delete();
        popsA = 0; popsB = 0; nA = 0;
        drive();
        reset = 1'b0;
        load_key_a(32'h77010203);
        send_a(8'h00);
        run_a(1, 40, ok);
        checks++;
        if (!ok || txA[0] !== 8'h77) begin
            failures++;
            $display("FAIL midsend_rekey: got %h, required 77", ok ? txA[0] : 8'hxx);
        end
        checks++;
        if (a_if.byte_count !== 16'd1) begin
            failures++;
            $display("FAIL midsend_count: got %0d, required 1", a_if.byte_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        a_if.tx_full = 1'b0; a_if.rekey = 1'b0;
        b_if.tx_full = 1'b0; b_if.rekey = 1'b0;
        nA = 0; popsA = 0; popsB = 0; keyB = 8'h00;
        for (int i = 0; i < 4; i++) keyA[i] = 8'h00;
        drive();
        test_reset();
        test_key_stream();
        test_backpressure();
        test_rekey();
        test_round_trip();
        test_random();
        test_edges();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
